if_fetch_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the byte address into the combinational instruction memory.
- Registers the returned word, PC and PC+4 into the IF/ID pipeline register for decode.
- Applies hazard-unit stalls and flushes, and branch/jump redirects.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/pc_next_sel.sv | 32 +++
 rtl/if_fetch_stage.sv | 103 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset constants, next-PC select codes and the IF/ID payload.
package mips_pkg;

    localparam int unsigned XLEN               = 32;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam int unsigned DEFAULT_IMEM_BYTES = 1024;
    localparam logic [31:0] DEFAULT_PC_RESET   = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_JUMP   = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority select: branch, jump, stall hold, fault park, then sequential.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            fault,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] next_pc_c,
    output pc_sel_e         sel_c
);

    // Branch beats jump because the branch belongs to the older instruction.
    always_comb begin
        next_pc_c = pc + XLEN'(4);
        sel_c     = SEL_SEQ;
        if (branch_taken) begin
            next_pc_c = branch_target;
            sel_c     = SEL_BRANCH;
        end else if (jump) begin
            next_pc_c = jump_target;
            sel_c     = SEL_JUMP;
        end else if (stall || fault) begin
            next_pc_c = pc;
            sel_c     = SEL_HOLD;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, sticky fetch fault and fetch counter.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = DEFAULT_PC_RESET,
    parameter int unsigned IMEM_BYTES = DEFAULT_IMEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc_plus4_o,
    output logic        ifid_valid_o,
    output logic        fetch_fault_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);
    localparam logic [XLEN-1:0] CNT_MAX    = '1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    pc_sel_e         sel;
    logic            fault;
    logic            capture;
    ifid_t           ifid_q;
    ifid_t           ifid_d;
    logic            fault_q;
    logic [XLEN-1:0] count_q;

    assign imem_addr_o = pc;
    assign pc_plus4    = pc + XLEN'(4);
    assign fault       = (pc[1:0] != 2'b00) || (pc >= IMEM_LIMIT);

    pc_next_sel u_pc_next_sel (
        .pc            (pc),
        .stall         (stall_i),
        .fault         (fault),
        .branch_taken  (branch_taken_i),
        .branch_target (branch_target_i),
        .jump          (jump_i),
        .jump_target   (jump_target_i),
        .next_pc_c     (next_pc),
        .sel_c         (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RESET;
        end else if (sel != SEL_HOLD) begin
            pc <= next_pc;
        end
    end

    // IF/ID next value: flush, then stall hold, then fault bubble, then normal capture.
    always_comb begin
        ifid_d  = ifid_q;
        capture = 1'b0;
        if (flush_i) begin
            ifid_d = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
        end else if (stall_i) begin
            ifid_d = ifid_q;
        end else if (fault) begin
            ifid_d = '{instr: NOP_INSTR, pc: pc, pc_plus4: pc_plus4, valid: 1'b0};
        end else begin
            ifid_d  = '{instr: imem_instr_i, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};
            capture = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q  <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            ifid_q <= ifid_d;
            if (!flush_i && !stall_i && fault) begin
                fault_q <= 1'b1;
            end
            if (capture && (count_q != CNT_MAX)) begin
                count_q <= count_q + XLEN'(1);
            end
        end
    end

    assign ifid_instr_o    = ifid_q.instr;
    assign ifid_pc_o       = ifid_q.pc;
    assign ifid_pc_plus4_o = ifid_q.pc_plus4;
    assign ifid_valid_o    = ifid_q.valid;
    assign fetch_fault_o   = fault_q;
    assign fetch_count_o   = count_q;

endmodule
